// File: rtl/toy_pkg.sv
// Shared constants and the response record used by the toy data-memory blocks.
package toy_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 30;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] data;
  } resp_t;

  // Even-parity bit: chosen so that data plus this bit has an even number of ones.
  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/toy_dmem_pipe.sv
// Fixed LAT-stage delay line for the response record; data only advances with valid,
// so the final stage holds the last valid read word between responses.
module toy_dmem_pipe
  import toy_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic  CLK,
  input  logic  RSTN,
  input  resp_t in_resp,
  output resp_t out_resp
);

  resp_t stage [LAT];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0].valid <= in_resp.valid;
      stage[0].err   <= in_resp.err;
      if (in_resp.valid) begin
        stage[0].data <= in_resp.data;
      end
      for (int i = 1; i < LAT; i++) begin
        stage[i].valid <= stage[i-1].valid;
        stage[i].err   <= stage[i-1].err;
        if (stage[i-1].valid) begin
          stage[i].data <= stage[i-1].data;
        end
      end
    end
  end

  assign out_resp = stage[LAT-1];

endmodule

// File: rtl/toy_dmem_resp.sv
// Single-port data memory with fixed read latency and error/parity reporting.
// Optional feature: TOY_DMEM_PARITY_EN adds per-word parity storage and the PINJ port.
module toy_dmem_resp
  import toy_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              DREQ,
  input  logic              DRW,
  input  logic [ADDR_W-1:0] DADDR,
  input  logic [DATA_W-1:0] DWDATA,
`ifdef TOY_DMEM_PARITY_EN
  input  logic              PINJ,
`endif
  output logic [DATA_W-1:0] DRDATA,
  output logic              DVALID,
  output logic              DERR,
  output logic [15:0]       REQCNT
);

  localparam int IDX_W = $clog2(DEPTH);

  // Handshake: a request is accepted on every rising edge where DREQ=1 (no ready);
  // a response is a one-cycle DVALID and/or DERR strobe, with no backpressure.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              wr_en;
  logic [DATA_W-1:0] rd_word;
  logic              par_err;
  resp_t             req_resp;
  resp_t             out_resp;
  logic [15:0]       reqcnt;

  assign idx      = DADDR[IDX_W-1:0];
  assign in_range = (DADDR < ADDR_W'(DEPTH));
  assign wr_en    = DREQ && !DRW && in_range;

  // Array contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[idx] <= DWDATA;
    end
  end

  assign rd_word = mem[idx];

`ifdef TOY_DMEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      par_mem[idx] <= even_par(DWDATA) ^ PINJ;
    end
  end

  assign par_err = (even_par(rd_word) != par_mem[idx]);
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    req_resp = '0;
    if (DREQ) begin
      if (DRW) begin
        req_resp.valid = 1'b1;
        if (in_range) begin
          req_resp.data = rd_word;
          req_resp.err  = par_err;
        end else begin
          req_resp.data = '0;
          req_resp.err  = 1'b1;
        end
      end else begin
        req_resp.err = !in_range;
      end
    end
  end

  toy_dmem_pipe #(
    .LAT (LAT)
  ) u_pipe (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .in_resp  (req_resp),
    .out_resp (out_resp)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      reqcnt <= '0;
    end else if (DREQ && (reqcnt != 16'hFFFF)) begin
      reqcnt <= reqcnt + 16'd1;
    end
  end

  assign DRDATA = out_resp.data;
  assign DVALID = out_resp.valid;
  assign DERR   = out_resp.err;
  assign REQCNT = reqcnt;

endmodule
